// File: rtl/core_int_ctrl_if.sv
// core_int_ctrl_if: interrupt request/acknowledge handshake between the controller and execute
interface core_int_ctrl_if #(
    parameter int XLEN = 64
);
    logic            int_req;
    logic [6:0]      int_cause;
    logic [XLEN-1:0] int_tvec;
    logic            int_ack;
    modport master (output int_req, int_cause, int_tvec, input int_ack);
    modport slave  (input int_req, int_cause, int_tvec, output int_ack);
endinterface

// File: rtl/core_int_ctrl.sv
// core_int_ctrl: machine-mode interrupt controller with fixed-priority arbitration and registered req/ack
module core_int_ctrl #(
    parameter int XLEN   = 64,
    parameter int NLOCAL = 16
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              int_sw,
    input  logic              int_ti,
    input  logic              int_ext,
    input  logic [NLOCAL-1:0] int_local,
    input  logic [NLOCAL-1:0] local_edge,
    input  logic [NLOCAL-1:0] mip_local_clr,
    input  logic [XLEN-1:0]   mtvec_base,
    input  logic [1:0]        mtvec_mode,
    input  logic              mstatus_mie,
    input  logic              mie_meie,
    input  logic              mie_mtie,
    input  logic              mie_msie,
    input  logic [NLOCAL-1:0] mie_local,
    output logic              mip_meip,
    output logic              mip_mtip,
    output logic              mip_msip,
    output logic [NLOCAL-1:0] mip_local,
    core_int_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t            state_q, state_d;
    logic [NLOCAL-1:0] prev_q, lpend_q, lpend_d, ack_clr;
    logic              int_req_q, int_req_d;
    logic [6:0]        cause_q, cause_d, win_cause;
    logic [XLEN-1:0]   tvec_q, tvec_d, base_al, win_tvec;
    logic [63:0]       cand;
    logic              any_cand, ack_fire;
    logic              unused_bits;

    assign unused_bits = ^{mtvec_mode[1], mtvec_base[1:0]};
    assign mip_meip = int_ext;
    assign mip_mtip = int_ti;
    assign mip_msip = int_sw;
    assign mip_local = (local_edge & lpend_q) | (~local_edge & int_local);
    assign ack_fire = (state_q == REQ) && bus.int_ack;
    assign base_al = {mtvec_base[XLEN-1:2], 2'b00};
    assign win_tvec = mtvec_mode[0] ? base_al + {{(XLEN-9){1'b0}}, win_cause, 2'b00} : base_al;
    assign bus.int_req = int_req_q;
    assign bus.int_cause = cause_q;
    assign bus.int_tvec = tvec_q;

    // Candidates indexed by cause; later assignments override earlier ones, so locals (highest index last) win
    always_comb begin
        cand = '0;
        cand[11] = int_ext & mie_meie;
        cand[3] = int_sw & mie_msie;
        cand[7] = int_ti & mie_mtie;
        for (int i = 0; i < NLOCAL; i++) cand[16+i] = mip_local[i] & mie_local[i];
        win_cause = cand[7] ? 7'd7 : 7'd0;
        if (cand[3]) win_cause = 7'd3;
        if (cand[11]) win_cause = 7'd11;
        for (int i = 0; i < NLOCAL; i++) if (cand[16+i]) win_cause = 7'(16 + i);
        any_cand = |cand;
    end

    // Edge-latched pending: a new rising edge beats any clear; level-mode lines leave lpend untouched
    always_comb begin
        for (int i = 0; i < NLOCAL; i++) begin
            ack_clr[i] = ack_fire && (cause_q == 7'(16 + i));
            lpend_d[i] = local_edge[i] ? ((int_local[i] & ~prev_q[i]) | (lpend_q[i] & ~(mip_local_clr[i] | ack_clr[i]))) : lpend_q[i];
        end
    end

    // Handshake FSM; HOLD arbitrates like IDLE so a new request can appear two cycles after ack
    always_comb begin
        state_d = state_q;
        int_req_d = int_req_q;
        cause_d = cause_q;
        tvec_d = tvec_q;
        case (state_q)
            REQ: begin
                if (bus.int_ack) begin
                    state_d = HOLD;
                    int_req_d = 1'b0;
                end else if (!mstatus_mie || !cand[cause_q[5:0]]) begin
                    state_d = IDLE;
                    int_req_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (mstatus_mie && any_cand) begin
                    state_d = REQ;
                    int_req_d = 1'b1;
                    cause_d = win_cause;
                    tvec_d = win_tvec;
                end
            end
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            int_req_q <= 1'b0;
            cause_q <= '0;
            tvec_q <= '0;
            lpend_q <= '0;
            prev_q <= '0;
        end else begin
            state_q <= state_d;
            int_req_q <= int_req_d;
            cause_q <= cause_d;
            tvec_q <= tvec_d;
            lpend_q <= lpend_d;
            prev_q <= int_local;
        end
    end
endmodule

// File: tb/tb_core_int_ctrl.sv
// tb_core_int_ctrl: directed self-checking bench for core_int_ctrl
module tb_core_int_ctrl;
    localparam int XLEN = 64;
    localparam int NLOCAL = 16;
    logic              g_clk = 1'b0;
    logic              g_resetn;
    logic              int_sw, int_ti, int_ext;
    logic [NLOCAL-1:0] int_local, local_edge, mip_local_clr, mie_local, mip_local;
    logic [XLEN-1:0]   mtvec_base;
    logic [1:0]        mtvec_mode;
    logic              mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic              mip_meip, mip_mtip, mip_msip;
    int                checks = 0;
    int                errors = 0;

    core_int_ctrl_if #(.XLEN(XLEN)) bus();

    core_int_ctrl #(.XLEN(XLEN), .NLOCAL(NLOCAL)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .int_sw(int_sw), .int_ti(int_ti), .int_ext(int_ext),
        .int_local(int_local), .local_edge(local_edge), .mip_local_clr(mip_local_clr),
        .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mstatus_mie(mstatus_mie),
        .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie), .mie_local(mie_local),
        .mip_meip(mip_meip), .mip_mtip(mip_mtip), .mip_msip(mip_msip), .mip_local(mip_local),
        .bus(bus)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs();
        int_sw = 0; int_ti = 0; int_ext = 0;
        int_local = '0; local_edge = '0; mip_local_clr = '0; mie_local = '0;
        mtvec_base = '0; mtvec_mode = 2'b00; mstatus_mie = 0;
        mie_meie = 0; mie_mtie = 0; mie_msie = 0; bus.int_ack = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        g_resetn = 0;
        tick(); tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.int_req); end
        checks++; if (bus.int_cause !== 7'd0) begin errors++; $display("FAIL reset_cause: got %0d exp 0", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'd0) begin errors++; $display("FAIL reset_tvec: got %h exp 0", bus.int_tvec); end
        checks++; if (mip_local !== 16'h0) begin errors++; $display("FAIL reset_mip_local: got %h exp 0", mip_local); end
        checks++; if ({mip_meip, mip_mtip, mip_msip} !== 3'b000) begin errors++; $display("FAIL reset_mip_std: got %b exp 000", {mip_meip, mip_mtip, mip_msip}); end
        g_resetn = 1;
    endtask

    task automatic test_direct_timer();
        mtvec_base = 64'h8000_0000; mtvec_mode = 2'b00;
        mstatus_mie = 1; mie_mtie = 1; int_ti = 1;
        tick();
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_req: got %b exp 1", bus.int_req); end
        checks++; if (bus.int_cause !== 7'd7) begin errors++; $display("FAIL timer_cause: got %0d exp 7", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h8000_0000) begin errors++; $display("FAIL timer_tvec: got %h exp 80000000", bus.int_tvec); end
        checks++; if (mip_mtip !== 1'b1) begin errors++; $display("FAIL timer_mip: got %b exp 1", mip_mtip); end
        bus.int_ack = 1;
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_hold: got %b exp 0", bus.int_req); end
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_rereq: got %b exp 1", bus.int_req); end
        bus.int_ack = 1; int_ti = 0; mie_mtie = 0;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_idle: got %b exp 0", bus.int_req); end
    endtask

    task automatic test_vectored_edge();
        mtvec_base = 64'h100; mtvec_mode = 2'b01;
        local_edge = 16'h0020; mie_local = 16'h0020;
        int_local = 16'h0020;
        tick();
        int_local = '0;
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL edge_latency: got %b exp 0", bus.int_req); end
        checks++; if (mip_local[5] !== 1'b1) begin errors++; $display("FAIL edge_lpend_set: got %b exp 1", mip_local[5]); end
        tick();
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL edge_req: got %b exp 1", bus.int_req); end
        checks++; if (bus.int_cause !== 7'd21) begin errors++; $display("FAIL edge_cause: got %0d exp 21", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h154) begin errors++; $display("FAIL edge_tvec: got %h exp 154", bus.int_tvec); end
        bus.int_ack = 1;
        tick();
        bus.int_ack = 0;
        checks++; if (mip_local[5] !== 1'b0) begin errors++; $display("FAIL edge_ack_clr: got %b exp 0", mip_local[5]); end
        tick(); tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL edge_no_second: got %b exp 0", bus.int_req); end
        local_edge = '0; mie_local = '0;
    endtask

    task automatic test_priority();
        mtvec_base = 64'h100; mtvec_mode = 2'b01;
        int_ext = 1; int_sw = 1; int_local = 16'h8001;
        mie_meie = 1; mie_msie = 1; mie_local = 16'h8001;
        tick();
        checks++; if (bus.int_cause !== 7'd31) begin errors++; $display("FAIL prio_local15: got %0d exp 31", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h17C) begin errors++; $display("FAIL prio_tvec31: got %h exp 17c", bus.int_tvec); end
        bus.int_ack = 1; mie_local = 16'h0001;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_cause !== 7'd16) begin errors++; $display("FAIL prio_local0: got %0d exp 16", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h140) begin errors++; $display("FAIL prio_tvec16: got %h exp 140", bus.int_tvec); end
        bus.int_ack = 1; mie_local = '0;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_cause !== 7'd11) begin errors++; $display("FAIL prio_mei: got %0d exp 11", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h12C) begin errors++; $display("FAIL prio_tvec11: got %h exp 12c", bus.int_tvec); end
        bus.int_ack = 1; mie_meie = 0;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_cause !== 7'd3) begin errors++; $display("FAIL prio_msi: got %0d exp 3", bus.int_cause); end
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL prio_msi_req: got %b exp 1", bus.int_req); end
        bus.int_ack = 1; int_ext = 0; int_sw = 0; int_local = '0; mie_msie = 0;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b exp 0", bus.int_req); end
    endtask

    task automatic test_no_rearb();
        mtvec_base = 64'h100; mtvec_mode = 2'b01;
        int_ti = 1; mie_mtie = 1;
        tick();
        checks++; if (bus.int_cause !== 7'd7) begin errors++; $display("FAIL norearb_first: got %0d exp 7", bus.int_cause); end
        int_ext = 1; mie_meie = 1;
        tick();
        checks++; if (bus.int_cause !== 7'd7) begin errors++; $display("FAIL norearb_hold: got %0d exp 7", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'h11C) begin errors++; $display("FAIL norearb_tvec: got %h exp 11c", bus.int_tvec); end
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL norearb_req: got %b exp 1", bus.int_req); end
        mstatus_mie = 0;
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL withdraw_req: got %b exp 0", bus.int_req); end
        checks++; if (bus.int_cause !== 7'd7) begin errors++; $display("FAIL withdraw_cause_held: got %0d exp 7", bus.int_cause); end
        mstatus_mie = 1;
        tick();
        checks++; if (bus.int_cause !== 7'd11) begin errors++; $display("FAIL withdraw_rearb: got %0d exp 11", bus.int_cause); end
        bus.int_ack = 1; int_ti = 0; int_ext = 0; mie_mtie = 0; mie_meie = 0;
        tick();
        bus.int_ack = 0;
        tick();
    endtask

    task automatic test_ack_beats_withdraw();
        local_edge = 16'h0020; mie_local = 16'h0020;
        int_local = 16'h0020;
        tick();
        int_local = '0;
        tick();
        checks++; if (bus.int_cause !== 7'd21) begin errors++; $display("FAIL ackwd_cause: got %0d exp 21", bus.int_cause); end
        bus.int_ack = 1; mstatus_mie = 0;
        tick();
        bus.int_ack = 0; mstatus_mie = 1;
        checks++; if (mip_local[5] !== 1'b0) begin errors++; $display("FAIL ackwd_lpend: got %b exp 0", mip_local[5]); end
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ackwd_req: got %b exp 0", bus.int_req); end
        local_edge = '0; mie_local = '0;
    endtask

    task automatic test_set_clr();
        local_edge = 16'h0004;
        int_local = 16'h0004; mip_local_clr = 16'h0004;
        tick();
        mip_local_clr = '0;
        checks++; if (mip_local[2] !== 1'b1) begin errors++; $display("FAIL setclr_set_wins: got %b exp 1", mip_local[2]); end
        tick();
        checks++; if (mip_local[2] !== 1'b1) begin errors++; $display("FAIL setclr_sticky: got %b exp 1", mip_local[2]); end
        mip_local_clr = 16'h0004;
        tick();
        mip_local_clr = '0;
        checks++; if (mip_local[2] !== 1'b0) begin errors++; $display("FAIL setclr_clear: got %b exp 0", mip_local[2]); end
        int_local = '0;
        tick();
        int_local = 16'h0004;
        tick();
        int_local = '0; local_edge = '0; mip_local_clr = 16'h0004;
        tick();
        checks++; if (mip_local[2] !== 1'b0) begin errors++; $display("FAIL setclr_level_view: got %b exp 0", mip_local[2]); end
        local_edge = 16'h0004; mip_local_clr = '0;
        tick();
        checks++; if (mip_local[2] !== 1'b1) begin errors++; $display("FAIL setclr_mode_hold: got %b exp 1", mip_local[2]); end
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL setclr_no_req: got %b exp 0", bus.int_req); end
        mip_local_clr = 16'h0004;
        tick();
        mip_local_clr = '0; local_edge = '0;
    endtask

    task automatic test_tvec_wrap();
        mtvec_base = '1; mtvec_mode = 2'b01;
        int_ti = 1; mie_mtie = 1;
        tick();
        checks++; if (bus.int_tvec !== 64'h18) begin errors++; $display("FAIL wrap_tvec: got %h exp 18", bus.int_tvec); end
        bus.int_ack = 1; mtvec_base = 64'h8000_0003; mtvec_mode = 2'b10;
        tick();
        bus.int_ack = 0;
        tick();
        checks++; if (bus.int_tvec !== 64'h8000_0000) begin errors++; $display("FAIL direct_mode_bit1: got %h exp 80000000", bus.int_tvec); end
        bus.int_ack = 1; int_ti = 0; mie_mtie = 0;
        tick();
        bus.int_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid_req();
        mtvec_base = 64'h100; mtvec_mode = 2'b01;
        int_ti = 1; mie_mtie = 1;
        local_edge = 16'h0020; int_local = 16'h0020;
        tick();
        int_local = '0;
        checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req: got %b exp 1", bus.int_req); end
        checks++; if (mip_local[5] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_lpend: got %b exp 1", mip_local[5]); end
        g_resetn = 0;
        tick();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b exp 0", bus.int_req); end
        checks++; if (bus.int_cause !== 7'd0) begin errors++; $display("FAIL rstmid_cause: got %0d exp 0", bus.int_cause); end
        checks++; if (bus.int_tvec !== 64'd0) begin errors++; $display("FAIL rstmid_tvec: got %h exp 0", bus.int_tvec); end
        checks++; if (mip_local[5] !== 1'b0) begin errors++; $display("FAIL rstmid_lpend: got %b exp 0", mip_local[5]); end
        g_resetn = 1;
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_direct_timer();
        test_vectored_edge();
        test_priority();
        test_no_rearb();
        test_ack_beats_withdraw();
        test_set_clr();
        test_tvec_wrap();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
